op_sequencer: RTL
=================

OP_SEQUENCER -- requirements
Module: op_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with the port list as follows.
- clk  input  1  rising-edge clock for all state
- reset  input  1  synchronous, active-high reset
- instr_valid  input  1  macro-instruction offered
- instr_opcode  input  3  macro opcode (see REQ-010)
- instr_count  input  4  iteration count; 0 means 16
- instr_ready  output  1  block can accept an instruction
- operacao  output  5  registered micro-op code to the downstream control decoder
- op_valid  output  1  operacao carries a real micro-op this cycle
- busy  output  1  expansion in progress (equals !instr_ready)
- done  output  1  one-cycle pulse: instruction finished
- err  output  1  sticky illegal-opcode flag

Function
REQ-002 Micro-op codes SHALL be: 0 LOAD_CLR, 1 LOAD_ADD, 2 CLRX_ADD, 3 SHR, 4 STORE, 31 NOP (hold; matches no decoder case).
REQ-003 A handshake SHALL occur on a rising edge where instr_valid and instr_ready are both 1; the block SHALL latch opcode and count at that edge.
REQ-004 instr_ready SHALL be 1 only in state IDLE; instr_valid while busy SHALL be ignored and not consumed.
REQ-005 States SHALL be IDLE, SINGLE, SHIFT, MUL_ADD, MUL_SHR, MUL_STORE.
REQ-006 The first micro-op SHALL appear on operacao with op_valid=1 in the cycle immediately after the accepting edge (latency 1).
REQ-007 In IDLE, operacao SHALL be 31 and op_valid 0.
REQ-008 On the edge leaving the last micro-op cycle, the FSM SHALL return to IDLE and done SHALL be 1 for exactly that following cycle, concurrent with instr_ready=1.
REQ-009 An instruction accepted during the done cycle SHALL emit its first micro-op in the next cycle (back-to-back, no bubble beyond the IDLE cycle).
REQ-010 Opcode expansion SHALL be:
- 0 LOAD -> one op 0
- 1 ADD -> one op 1
- 2 MOVE -> one op 2
- 3 SHR -> N ops of 3
- 4 STORE -> one op 4
- 5 MUL -> N pairs (2, 3), then one 4; 2N+1 cycles
- 6, 7 illegal
REQ-011 N SHALL equal instr_count, with 0 meaning 16.
REQ-012 The remaining-iteration counter SHALL be 5 bits wide, decrement once per SHR op (SHIFT) or per MUL_SHR, and SHALL never wrap below 1 while active.
REQ-013 An illegal opcode SHALL be consumed, SHALL set err at the accepting edge, SHALL pulse done in the next cycle, SHALL leave the FSM in IDLE and SHALL emit no op_valid.
REQ-014 err SHALL remain 1 until reset; later legal instructions SHALL execute normally.
REQ-015 operacao, op_valid, done and err SHALL all be registered outputs.

Reset
REQ-016 When reset=1 at an edge: state IDLE, operacao=31, op_valid=0, done=0, err=0, counter=0, instr_ready=1 in the following cycle.
REQ-017 Reset SHALL override a handshake at the same edge; that instruction SHALL be dropped.
REQ-018 Reset during an expansion SHALL abort it with no done pulse; the next cycle SHALL show NOP.

Structure
REQ-019 A shared package SHALL hold the macro opcode constants, the micro-op codes including NOP=31, and the state encoding.
REQ-020 A single sub-module op_down_counter SHALL be used (load N, decrement, last flag); everything else SHALL stay in op_sequencer.

Verification
REQ-021 Reset, then idle -> operacao=31, op_valid=0, instr_ready=1, done=0, err=0.
REQ-022 LOAD accepted at edge k -> cycle k+1: operacao=0, op_valid=1; cycle k+2: done=1, operacao=31.
REQ-023 SHR count=3 -> op 3 for 3 cycles, then done; SHR count=0 -> op 3 for 16 cycles, then done.
REQ-024 MUL count=2 with instr_valid held high throughout -> ops 2,3,2,3,4 in consecutive cycles; second instruction accepted only in the done cycle.
REQ-025 Opcode 7 -> err=1 and done=1 next cycle, op_valid stays 0; a following ADD -> op 1 with err still 1.
REQ-026 Reset asserted during the third micro-op of MUL count=4 -> next cycle operacao=31, op_valid=0, no done, instr_ready=1.

Source files
------------

// File: rtl/op_sequencer_pkg.sv
// Shared constants for the macro-op sequencer: macro opcodes,
// micro-op codes and the FSM state encoding.
package op_sequencer_pkg;

    localparam logic [2:0] MAC_LOAD  = 3'd0;
    localparam logic [2:0] MAC_ADD   = 3'd1;
    localparam logic [2:0] MAC_MOVE  = 3'd2;
    localparam logic [2:0] MAC_SHR   = 3'd3;
    localparam logic [2:0] MAC_STORE = 3'd4;
    localparam logic [2:0] MAC_MUL   = 3'd5;

    localparam logic [4:0] MOP_LOAD_CLR = 5'd0;
    localparam logic [4:0] MOP_LOAD_ADD = 5'd1;
    localparam logic [4:0] MOP_CLRX_ADD = 5'd2;
    localparam logic [4:0] MOP_SHR      = 5'd3;
    localparam logic [4:0] MOP_STORE    = 5'd4;
    localparam logic [4:0] MOP_NOP      = 5'd31;

    localparam int CNT_W = 5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SINGLE,
        S_SHIFT,
        S_MUL_ADD,
        S_MUL_SHR,
        S_MUL_STORE
    } state_e;

    // A count field of zero stands for the full sixteen iterations.
    function automatic logic [CNT_W-1:0] iter_count(input logic [3:0] c);
        return (c == 4'd0) ? 5'd16 : {1'b0, c};
    endfunction

endpackage

// File: rtl/op_down_counter.sv
// Remaining-iteration counter: loads N, counts down per iteration
// and flags the final iteration; it never steps below 1.
module op_down_counter
    import op_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);

    logic [CNT_W-1:0] r_cnt;

    // Load on acceptance, otherwise step down while above one.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt > 5'd1)) begin
            r_cnt <= r_cnt - 5'd1;
        end
    end

    assign o_last = (r_cnt == 5'd1);

endmodule

// File: rtl/op_sequencer.sv
// Expands macro-instructions into a registered stream of micro-ops
// for the downstream control decoder.
module op_sequencer
    import op_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [2:0] instr_opcode,
    input  logic [3:0] instr_count,
    output logic       instr_ready,
    output logic [4:0] operacao,
    output logic       op_valid,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_e     r_state;
    state_e     w_state_n;
    logic [4:0] r_op;
    logic [4:0] w_op_n;
    logic       r_op_valid;
    logic       w_op_valid_n;
    logic       r_done;
    logic       w_done_n;
    logic       r_err;
    logic       w_err_set;
    logic       w_accept;
    logic       w_load;
    logic       w_dec;
    logic       w_last;

    assign w_accept    = instr_valid && (r_state == S_IDLE);
    assign instr_ready = (r_state == S_IDLE);
    assign busy        = !instr_ready;
    assign operacao    = r_op;
    assign op_valid    = r_op_valid;
    assign done        = r_done;
    assign err         = r_err;

    op_down_counter u_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (iter_count(instr_count)),
        .i_dec      (w_dec),
        .o_last     (w_last)
    );

    // State and all outputs are registered; reset wins over a handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_op       <= MOP_NOP;
            r_op_valid <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_op       <= w_op_n;
            r_op_valid <= w_op_valid_n;
            r_done     <= w_done_n;
            r_err      <= r_err | w_err_set;
        end
    end

    // Next state plus the micro-op to present in the following cycle.
    always_comb begin
        w_state_n    = r_state;
        w_op_n       = MOP_NOP;
        w_op_valid_n = 1'b0;
        w_done_n     = 1'b0;
        w_err_set    = 1'b0;
        w_load       = 1'b0;
        w_dec        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_load       = 1'b1;
                    w_op_valid_n = 1'b1;
                    case (instr_opcode)
                        MAC_LOAD: begin
                            w_state_n = S_SINGLE;
                            w_op_n    = MOP_LOAD_CLR;
                        end
                        MAC_ADD: begin
                            w_state_n = S_SINGLE;
                            w_op_n    = MOP_LOAD_ADD;
                        end
                        MAC_MOVE: begin
                            w_state_n = S_SINGLE;
                            w_op_n    = MOP_CLRX_ADD;
                        end
                        MAC_STORE: begin
                            w_state_n = S_SINGLE;
                            w_op_n    = MOP_STORE;
                        end
                        MAC_SHR: begin
                            w_state_n = S_SHIFT;
                            w_op_n    = MOP_SHR;
                        end
                        MAC_MUL: begin
                            w_state_n = S_MUL_ADD;
                            w_op_n    = MOP_CLRX_ADD;
                        end
                        default: begin
                            w_op_valid_n = 1'b0;
                            w_err_set    = 1'b1;
                            w_done_n     = 1'b1;
                        end
                    endcase
                end
            end
            S_SINGLE: begin
                w_state_n = S_IDLE;
                w_done_n  = 1'b1;
            end
            S_SHIFT: begin
                w_dec = 1'b1;
                if (w_last) begin
                    w_state_n = S_IDLE;
                    w_done_n  = 1'b1;
                end else begin
                    w_op_n       = MOP_SHR;
                    w_op_valid_n = 1'b1;
                end
            end
            S_MUL_ADD: begin
                w_state_n    = S_MUL_SHR;
                w_op_n       = MOP_SHR;
                w_op_valid_n = 1'b1;
            end
            S_MUL_SHR: begin
                w_dec        = 1'b1;
                w_op_valid_n = 1'b1;
                if (w_last) begin
                    w_state_n = S_MUL_STORE;
                    w_op_n    = MOP_STORE;
                end else begin
                    w_state_n = S_MUL_ADD;
                    w_op_n    = MOP_CLRX_ADD;
                end
            end
            S_MUL_STORE: begin
                w_state_n = S_IDLE;
                w_done_n  = 1'b1;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

endmodule
